// File: rtl/div_ratio_meter.sv
// div_ratio_meter: measures a divided clock clk_div against its source clk_in.
// It runs over a window of WIN clk_div periods and reports:
//   - the total number of clk_in cycles,
//   - how many periods were short (LO_P), long (HI_P) or illegal,
//   - the last measured period,
//   - whether the window was aborted because the period counter saturated.
// Optional macro DIV_RATIO_SYNC_EN adds a 2-flop synchronizer on clk_div so
// that it may come from an asynchronous source.
//
// state | meaning
// IDLE  | results held, waiting for start
// ARM   | waiting for the first clk_div rise (pc counts the wait)
// MEAS  | measuring periods, pc counts clk_in cycles since the last rise
// FIN   | done pulse, results valid
module div_ratio_meter #(
    parameter int WIN   = 10,
    parameter int LO_P  = 8,
    parameter int HI_P  = 9,
    parameter int CNT_W = 8,
    parameter int TOT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clk_div,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [TOT_W-1:0] total_cycles,
    output logic [7:0]       n_lo,
    output logic [7:0]       n_hi,
    output logic [7:0]       n_err,
    output logic [CNT_W-1:0] last_period,
    output logic             timeout
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] MEAS = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    localparam logic [CNT_W-1:0] PC_MAX    = '1;
    localparam logic [CNT_W-1:0] PC_SAT_M1 = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] LO_V      = CNT_W'(LO_P);
    localparam logic [CNT_W-1:0] HI_V      = CNT_W'(HI_P);
    localparam logic [7:0]       WIN_V     = 8'(WIN);

    logic [1:0]       state;
    logic [CNT_W-1:0] pc;
    logic [7:0]       k;
    logic [7:0]       k_nxt;
    logic             div_smp;
    logic             d1;
    logic             rise;
    logic             accept;

`ifdef DIV_RATIO_SYNC_EN
    logic div_s1;
    logic div_s2;

    // Two-flop synchronizer for an asynchronous clk_div.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            div_s1 <= 1'b0;
            div_s2 <= 1'b0;
        end else begin
            div_s1 <= clk_div;
            div_s2 <= div_s1;
        end
    end

    assign div_smp = div_s2;
`else
    assign div_smp = clk_div;
`endif

    // Edge history for rising-edge detection of the sampled divided clock.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) d1 <= 1'b0;
        else      d1 <= div_smp;
    end

    assign rise   = div_smp & ~d1;
    assign k_nxt  = k + 8'd1;
    // A start coinciding with the done pulse is taken, since the FSM is idle
    // from the next cycle anyway.
    assign accept = start && ((state == IDLE) || (state == FIN));
    assign busy   = (state == ARM) || (state == MEAS);
    assign done   = (state == FIN);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Measurement FSM, period counter and result accumulation.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            pc           <= '0;
            k            <= '0;
            total_cycles <= '0;
            n_lo         <= '0;
            n_hi         <= '0;
            n_err        <= '0;
            last_period  <= '0;
            timeout      <= 1'b0;
        end else if (accept) begin
            state        <= ARM;
            pc           <= '0;
            k            <= '0;
            total_cycles <= '0;
            n_lo         <= '0;
            n_hi         <= '0;
            n_err        <= '0;
            last_period  <= '0;
            timeout      <= 1'b0;
        end else begin
            case (state)
                ARM: begin
                    if (rise) begin
                        pc    <= CNT_W'(1);
                        state <= MEAS;
                    end else if (pc == PC_SAT_M1) begin
                        pc      <= PC_MAX;
                        timeout <= 1'b1;
                        state   <= FIN;
                    end else begin
                        pc <= pc + CNT_W'(1);
                    end
                end
                MEAS: begin
                    if (rise) begin
                        last_period  <= pc;
                        total_cycles <= total_cycles + TOT_W'(pc);
                        if (pc == LO_V)      n_lo  <= sat_inc(n_lo);
                        else if (pc == HI_V) n_hi  <= sat_inc(n_hi);
                        else                 n_err <= sat_inc(n_err);
                        pc <= CNT_W'(1);
                        k  <= k_nxt;
                        if (k_nxt == WIN_V) state <= FIN;
                    end else if (pc == PC_SAT_M1) begin
                        // The partial period is dropped, not accumulated.
                        pc      <= PC_MAX;
                        timeout <= 1'b1;
                        state   <= FIN;
                    end else begin
                        pc <= pc + CNT_W'(1);
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ratio_meter.sv
// Directed testbench for div_ratio_meter with default parameters.
module tb_div_ratio_meter;

    logic        clk_in = 1'b0;
    logic        rst = 1'b0;
    logic        clk_div = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] total_cycles;
    logic [7:0]  n_lo;
    logic [7:0]  n_hi;
    logic [7:0]  n_err;
    logic [7:0]  last_period;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    int pat[$];
    bit stuck;
    int done_cnt;
    int busy_cnt;
    int lat_ok;

    div_ratio_meter dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .clk_div      (clk_div),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .total_cycles (total_cycles),
        .n_lo         (n_lo),
        .n_hi         (n_hi),
        .n_err        (n_err),
        .last_period  (last_period),
        .timeout      (timeout)
    );

    always #5 clk_in = ~clk_in;

    // Pulse start, then generate clk_div from pat (looped) for ncyc cycles.
    // Outputs are sampled, and inputs driven, on the falling edge.
    task automatic run(input int ncyc, input int extra_start, input int rst_at);
        int pi = 0;
        int j = 0;
        int rises = 0;
        int last_rise = -10;
        int p;
        done_cnt = 0;
        busy_cnt = 0;
        lat_ok = 0;
        @(negedge clk_in);
        start = 1'b1;
        clk_div = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk_in);
            if (done) begin
                done_cnt++;
                if (rises == 11 && last_rise == c - 1) lat_ok = 1;
            end
            if (busy) busy_cnt++;
            start = (c == extra_start);
            if (c == rst_at) rst = 1'b0;
            if (c == rst_at + 2) rst = 1'b1;
            if (stuck) begin
                clk_div = 1'b0;
            end else begin
                p = pat[pi];
                clk_div = (j < p / 2);
                if (j == 0) begin
                    rises++;
                    last_rise = c;
                end
                j++;
                if (j == p) begin
                    j = 0;
                    pi = (pi + 1) % pat.size();
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            clk_div = ~clk_div;
        end
        checks++;
        if ({busy, done, total_cycles, n_lo, n_hi, n_err, last_period, timeout} !== '0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%h required 0",
                     {busy, done, total_cycles, n_lo, n_hi, n_err, last_period, timeout});
        end
        rst = 1'b1;
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            clk_div = ~clk_div;
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        checks++;
        if (done_cnt !== 0 || busy_cnt !== 0) begin
            errors++;
            $display("FAIL reset_idle: done_cnt=%0d busy_cnt=%0d required 0 0", done_cnt, busy_cnt);
        end
        checks++;
        if (total_cycles !== 16'd0 || last_period !== 8'd0) begin
            errors++;
            $display("FAIL reset_results: total=%0d last=%0d required 0 0", total_cycles, last_period);
        end
    endtask

    task automatic test_const8();
        pat = '{8};
        stuck = 0;
        run(100, -1, -10);
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL const8_done_cnt: got %0d required 1", done_cnt);
        end
        checks++;
        if (lat_ok !== 1) begin
            errors++;
            $display("FAIL const8_latency: got %0d required 1", lat_ok);
        end
        checks++;
        if (total_cycles !== 16'd80 || n_lo !== 8'd10 || n_hi !== 8'd0 || n_err !== 8'd0) begin
            errors++;
            $display("FAIL const8_counts: total=%0d lo=%0d hi=%0d err=%0d required 80 10 0 0",
                     total_cycles, n_lo, n_hi, n_err);
        end
        checks++;
        if (last_period !== 8'd8 || timeout !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL const8_last: last=%0d timeout=%0d busy=%0d required 8 0 0",
                     last_period, timeout, busy);
        end
    endtask

    task automatic test_fractional();
        pat = '{8, 8, 8, 9, 9, 9, 9, 9, 9, 9};
        stuck = 0;
        run(110, -1, -10);
        checks++;
        if (done_cnt !== 1 || total_cycles !== 16'd87) begin
            errors++;
            $display("FAIL frac_total: done_cnt=%0d total=%0d required 1 87", done_cnt, total_cycles);
        end
        checks++;
        if (n_lo !== 8'd3 || n_hi !== 8'd7 || n_err !== 8'd0 || last_period !== 8'd9) begin
            errors++;
            $display("FAIL frac_counts: lo=%0d hi=%0d err=%0d last=%0d required 3 7 0 9",
                     n_lo, n_hi, n_err, last_period);
        end
    endtask

    task automatic test_inject_err();
        pat = '{9, 9, 9, 9, 12, 9, 9, 9, 9, 9};
        stuck = 0;
        run(120, -1, -10);
        checks++;
        if (done_cnt !== 1 || total_cycles !== 16'd93) begin
            errors++;
            $display("FAIL inject_total: done_cnt=%0d total=%0d required 1 93", done_cnt, total_cycles);
        end
        checks++;
        if (n_lo !== 8'd0 || n_hi !== 8'd9 || n_err !== 8'd1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL inject_counts: lo=%0d hi=%0d err=%0d timeout=%0d required 0 9 1 0",
                     n_lo, n_hi, n_err, timeout);
        end
    endtask

    task automatic test_stuck_low();
        stuck = 1;
        run(300, -1, -10);
        stuck = 0;
        checks++;
        if (done_cnt !== 1 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL stuck_timeout: done_cnt=%0d timeout=%0d required 1 1", done_cnt, timeout);
        end
        checks++;
        if (busy_cnt !== 255) begin
            errors++;
            $display("FAIL stuck_arm_cycles: got %0d required 255", busy_cnt);
        end
        checks++;
        if (total_cycles !== 16'd0 || n_lo !== 8'd0 || n_hi !== 8'd0 || n_err !== 8'd0 || last_period !== 8'd0) begin
            errors++;
            $display("FAIL stuck_results: total=%0d lo=%0d hi=%0d err=%0d last=%0d required all 0",
                     total_cycles, n_lo, n_hi, n_err, last_period);
        end
    endtask

    task automatic test_restart_ignored();
        pat = '{8};
        stuck = 0;
        run(100, 30, -10);
        checks++;
        if (done_cnt !== 1 || total_cycles !== 16'd80 || n_lo !== 8'd10) begin
            errors++;
            $display("FAIL restart_ignored: done_cnt=%0d total=%0d lo=%0d required 1 80 10",
                     done_cnt, total_cycles, n_lo);
        end
    endtask

    task automatic test_mid_reset();
        pat = '{9};
        stuck = 0;
        run(100, -1, 40);
        checks++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_done: done_cnt=%0d busy=%0d required 0 0", done_cnt, busy);
        end
        checks++;
        if (total_cycles !== 16'd0 || n_hi !== 8'd0 || last_period !== 8'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: total=%0d hi=%0d last=%0d timeout=%0d required 0 0 0 0",
                     total_cycles, n_hi, last_period, timeout);
        end
        run(110, -1, -10);
        checks++;
        if (done_cnt !== 1 || total_cycles !== 16'd90 || n_hi !== 8'd10 || n_lo !== 8'd0 || n_err !== 8'd0) begin
            errors++;
            $display("FAIL midrst_fresh: done_cnt=%0d total=%0d hi=%0d lo=%0d err=%0d required 1 90 10 0 0",
                     done_cnt, total_cycles, n_hi, n_lo, n_err);
        end
    endtask

    initial begin
        test_reset();
        test_const8();
        test_fractional();
        test_inject_err();
        test_stuck_low();
        test_restart_ignored();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
